// File: rtl/alu_slice.sv
// Bit-slice ALU (AND/OR/ADD/SUB/SLT) with a combinational result path and a
// registered copy of every output for pipelined use.
module alu_slice #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             slt_in_i,
  input  logic             adder_cin_i,
  input  logic [2:0]       op_i,
  output logic             cout_o,
  output logic             s_o,
  output logic [Width-1:0] result_o,
  output logic             cout_q_o,
  output logic             s_q_o,
  output logic [Width-1:0] result_q_o
);

  logic [Width-1:0] bb;
  logic [Width-1:0] sum;
  logic [Width:0]   carry;
  logic [Width-1:0] result_d;

  // Ripple adder on a + (b ^ invert) + cin; carry-out and MSB sum are valid for every op.
  always_comb begin
    bb       = b_i ^ {Width{op_i[2]}};
    carry    = '0;
    sum      = '0;
    carry[0] = adder_cin_i;
    for (int i = 0; i < int'(Width); i++) begin
      sum[i]     = a_i[i] ^ bb[i] ^ carry[i];
      carry[i+1] = (a_i[i] & bb[i]) | (a_i[i] & carry[i]) | (bb[i] & carry[i]);
    end
  end

  always_comb begin
    result_d = '0;
    unique case (op_i[1:0])
      2'b00:   result_d = a_i & bb;
      2'b01:   result_d = a_i | bb;
      2'b10:   result_d = sum;
      default: result_d[0] = slt_in_i;
    endcase
  end

  assign cout_o   = carry[Width];
  assign s_o      = sum[Width-1];
  assign result_o = result_d;

  logic             cout_q;
  logic             s_q;
  logic [Width-1:0] result_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cout_q   <= 1'b0;
      s_q      <= 1'b0;
      result_q <= '0;
    end else begin
      cout_q   <= cout_o;
      s_q      <= s_o;
      result_q <= result_d;
    end
  end

  assign cout_q_o   = cout_q;
  assign s_q_o      = s_q;
  assign result_q_o = result_q;

endmodule

// File: tb/tb_alu_slice.sv
// Self-checking bench for alu_slice: vector table for the combinational path, a scoreboard
// queue for the registered copies, and hand-written reset sequences.
module tb_alu_slice;

  logic       clk;
  logic       rst_n;
  logic [0:0] a;
  logic [0:0] b;
  logic       slt_in;
  logic       cin;
  logic [2:0] op;
  logic       cout;
  logic       s;
  logic [0:0] result;
  logic       cout_q;
  logic       s_q;
  logic [0:0] result_q;

  alu_slice #(.Width(1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .a_i         (a),
    .b_i         (b),
    .slt_in_i    (slt_in),
    .adder_cin_i (cin),
    .op_i        (op),
    .cout_o      (cout),
    .s_o         (s),
    .result_o    (result),
    .cout_q_o    (cout_q),
    .s_q_o       (s_q),
    .result_q_o  (result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       a;
    logic       b;
    logic [2:0] op;
    logic       slt;
    logic       cin;
    logic       exp_res;
    logic       exp_s;
    logic       exp_cout;
  } vec_t;

  typedef struct {
    string name;
    logic  cout;
    logic  s;
    logic  res;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  function automatic vec_t model(input string name, input logic va, input logic vb,
                                 input logic [2:0] vop, input logic vslt, input logic vcin);
    vec_t   v;
    logic   bbv;
    int     total;
    v.name = name; v.a = va; v.b = vb; v.op = vop; v.slt = vslt; v.cin = vcin;
    bbv   = vb ^ vop[2];
    total = int'(va) + int'(bbv) + int'(vcin);
    v.exp_s    = (total % 2) == 1;
    v.exp_cout = total >= 2;
    case (vop[1:0])
      2'b00:   v.exp_res = va & bbv;
      2'b01:   v.exp_res = va | bbv;
      2'b10:   v.exp_res = v.exp_s;
      default: v.exp_res = vslt;
    endcase
    return v;
  endfunction

  function automatic vec_t hand(input string name, input logic va, input logic vb,
                                input logic [2:0] vop, input logic vslt, input logic vcin,
                                input logic res, input logic vs, input logic vc);
    vec_t v;
    v.name = name; v.a = va; v.b = vb; v.op = vop; v.slt = vslt; v.cin = vcin;
    v.exp_res = res; v.exp_s = vs; v.exp_cout = vc;
    return v;
  endfunction

  task automatic pop_and_check();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.name, ".cout_q"}, cout_q, e.cout);
    check({e.name, ".s_q"}, s_q, e.s);
    check({e.name, ".result_q"}, result_q[0], e.res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;

    // Hand-computed directed cases from the adder/logic equations.
    vecs.push_back(hand("and11",  1, 1, 3'b000, 0, 0, 1, 0, 1));
    vecs.push_back(hand("or01",   0, 1, 3'b001, 0, 0, 1, 1, 0));
    vecs.push_back(hand("and10",  1, 0, 3'b000, 0, 0, 0, 1, 0));
    vecs.push_back(hand("add110", 1, 1, 3'b010, 0, 0, 0, 0, 1));
    vecs.push_back(hand("add101", 1, 0, 3'b010, 0, 1, 0, 0, 1));
    vecs.push_back(hand("sub11",  1, 1, 3'b110, 0, 1, 0, 0, 1));
    vecs.push_back(hand("sub01",  0, 1, 3'b110, 0, 1, 1, 1, 0));
    vecs.push_back(hand("slt1",   0, 1, 3'b111, 1, 1, 1, 1, 0));
    vecs.push_back(hand("slt0",   0, 1, 3'b111, 0, 1, 0, 1, 0));
    vecs.push_back(hand("andn10", 1, 0, 3'b100, 0, 0, 1, 0, 1));
    for (int i = 0; i < 128; i++) begin
      logic [6:0] k;
      k = 7'(i);
      vecs.push_back(model($sformatf("sweep%0d", i), k[6], k[5], k[4:2], k[1], k[0]));
    end

    rst_n = 1'b0; a = 1'b0; b = 1'b0; slt_in = 1'b0; cin = 1'b0; op = 3'b000;
    #1;
    check("reset.cout_q", cout_q, 1'b0);
    check("reset.s_q", s_q, 1'b0);
    check("reset.result_q", result_q[0], 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold.cout_q", cout_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      pop_and_check();
      v = vecs[i];
      a = v.a; b = v.b; op = v.op; slt_in = v.slt; cin = v.cin;
      #1;
      check({v.name, ".result"}, result[0], v.exp_res);
      check({v.name, ".s"}, s, v.exp_s);
      check({v.name, ".cout"}, cout, v.exp_cout);
      e.name = v.name; e.cout = v.exp_cout; e.s = v.exp_s; e.res = v.exp_res;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    pop_and_check();
    check("scoreboard_drained", sb.size() == 0, 1'b1);

    // Mid-operation reset: load OR a=1 b=0 (result_q=1), then ADD 1+1 with reset pulsed.
    a = 1'b1; b = 1'b0; op = 3'b001; cin = 1'b0; slt_in = 1'b0;
    @(posedge clk);
    #1;
    check("preload.result_q", result_q[0], 1'b1);
    a = 1'b1; b = 1'b1; op = 3'b010; cin = 1'b0;
    @(posedge clk);
    #1;
    check("preload.cout_q", cout_q, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.cout_q", cout_q, 1'b0);
    check("async_rst.result_q", result_q[0], 1'b0);
    check("async_rst.comb_cout", cout, 1'b1);
    b = 1'b0;
    #1;
    check("async_rst.comb_tracks", result[0], 1'b1);
    b = 1'b1;
    @(posedge clk);
    #1;
    check("rst_held.cout_q", cout_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_pre_edge.cout_q", cout_q, 1'b0);
    @(posedge clk);
    #1;
    check("release.cout_q", cout_q, 1'b1);
    check("release.result_q", result_q[0], 1'b0);
    check("release.s_q", s_q, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
